// File: rtl/ps_pkg.sv
// Shared program-sequencer types: loop-stack entry, loop FSM encoding, default sizes.
package ps_pkg;

  localparam int unsigned DEF_LP_DEPTH = 4;
  localparam int unsigned DEF_AW       = 16;
  localparam int unsigned DEF_CW       = 16;

  // One DO UNTIL loop: first body address, last body address, remaining iterations.
  typedef struct packed {
    logic [DEF_AW-1:0] start_add;
    logic [DEF_AW-1:0] end_add;
    logic [DEF_CW-1:0] cnt;
  } lp_entry_t;

  typedef enum logic {
    LP_IDLE = 1'b0,
    LP_ACT  = 1'b1
  } lp_state_e;

endpackage

// File: rtl/ps_lp_stack.sv
// LIFO loop stack. Pop/decrement act on the current top, then a push lands above
// what remains; pop+push together overwrite the top slot in place.
// The caller guarantees: pop/dec only when non-empty, push only when not full
// (or together with pop), dec only when top count > 1.
module ps_lp_stack
  import ps_pkg::*;
#(
  parameter int unsigned LP_DEPTH = DEF_LP_DEPTH,
  localparam int unsigned PW = $clog2(LP_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            dec_top_i,
  input  lp_entry_t       push_entry_i,
  output lp_entry_t       top_o,
  output logic [PW-1:0]   ptr_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned IW = (LP_DEPTH > 1) ? $clog2(LP_DEPTH) : 1;

  lp_entry_t     mem_q [LP_DEPTH];
  lp_entry_t     mem_d [LP_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] top_idx, new_idx;

  assign top_idx = IW'(ptr_q - PW'(1));
  assign new_idx = IW'(ptr_q);

  // Next stack contents: retire/decrement the top first, then push.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (pop_i) begin
      if (push_i) begin
        mem_d[top_idx] = push_entry_i;
      end else begin
        ptr_d = ptr_q - PW'(1);
      end
    end else begin
      if (dec_top_i) begin
        mem_d[top_idx].cnt = mem_q[top_idx].cnt - DEF_CW'(1);
      end
      if (push_i) begin
        mem_d[new_idx] = push_entry_i;
        ptr_d          = ptr_q + PW'(1);
      end
    end
  end

  // Stack storage and pointer; reset empties the stack and clears all entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      for (int i = 0; i < int'(LP_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < int'(LP_DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign empty_o = (ptr_q == '0);
  assign full_o  = (ptr_q == PW'(LP_DEPTH));
  assign ptr_o   = ptr_q;
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

endmodule

// File: rtl/ps_loop_ctrl.sv
// Zero-overhead DO UNTIL loop sequencer: compares fetch address with the top loop's
// end address and redirects fetch to its start until the count is exhausted.
// Optional sticky status {overflow, full, empty} built when PS_LOOP_STCKY_EN is defined.
// AW/CW must match the package entry widths.
module ps_loop_ctrl
  import ps_pkg::*;
#(
  parameter int unsigned LP_DEPTH = DEF_LP_DEPTH,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ps_faddr,
  input  logic          ps_lp_stall,
  input  logic          ps_lp_push,
  input  logic [AW-1:0] ps_lp_start_add,
  input  logic [AW-1:0] ps_lp_end_add,
  input  logic [CW-1:0] ps_lp_cnt,
  input  logic          ps_lp_pop,
  output logic          ps_lp_jmp,
  output logic [AW-1:0] ps_lp_jmp_add,
  output logic          ps_lp_act,
  output logic [CW-1:0] ps_lp_curcnt,
  output logic          ps_lp_err,
  output logic [2:0]    ps_lp_stcky
);

  localparam int unsigned PW = $clog2(LP_DEPTH + 1);

  lp_entry_t     top, push_entry;
  logic [PW-1:0] ptr;
  logic          full, empty;
  lp_state_e     state_q, state_d;
  logic          err_q, err_d;
  logic          hit_c, more_c, term_c;
  logic          pop_ok_c, pop_rej_c, stk_pop_c, stk_dec_c;
  logic          cnt_zero_c, push_ok_c, push_rej_c;

  assign push_entry = '{start_add: ps_lp_start_add, end_add: ps_lp_end_add, cnt: ps_lp_cnt};

  ps_lp_stack #(
    .LP_DEPTH (LP_DEPTH)
  ) u_stack (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_ok_c),
    .pop_i        (stk_pop_c),
    .dec_top_i    (stk_dec_c),
    .push_entry_i (push_entry),
    .top_o        (top),
    .ptr_o        (ptr),
    .full_o       (full),
    .empty_o      (empty)
  );

  // End-of-loop compare against the top entry (zero latency).
  always_comb begin
    hit_c  = (state_q == LP_ACT) && !ps_lp_stall && (ps_faddr == top.end_add);
    more_c = (top.cnt > DEF_CW'(1));
    term_c = hit_c && !more_c;
  end

  // Arbitration: terminal and explicit pop merge into one pop; push may replace when full.
  always_comb begin
    pop_ok_c   = ps_lp_pop && !empty;
    pop_rej_c  = ps_lp_pop && empty;
    stk_pop_c  = term_c || pop_ok_c;
    stk_dec_c  = hit_c && more_c && !pop_ok_c;
    cnt_zero_c = (ps_lp_cnt == '0);
    push_ok_c  = ps_lp_push && !cnt_zero_c && (!full || stk_pop_c);
    push_rej_c = ps_lp_push && !push_ok_c;
    err_d      = push_rej_c || pop_rej_c;
  end

  // FSM state and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LP_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // FSM next state: active while at least one loop is on the stack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LP_IDLE: if (push_ok_c) state_d = LP_ACT;
      LP_ACT:  if (stk_pop_c && !push_ok_c && (ptr == PW'(1))) state_d = LP_IDLE;
      default: state_d = LP_IDLE;
    endcase
  end

  // FSM outputs: redirect only while more iterations remain.
  always_comb begin
    ps_lp_act     = (state_q == LP_ACT);
    ps_lp_jmp     = hit_c && more_c;
    ps_lp_jmp_add = top.start_add;
    ps_lp_curcnt  = top.cnt;
  end

  assign ps_lp_err = err_q;

`ifdef PS_LOOP_STCKY_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q || (ps_lp_push && !cnt_zero_c && full && !stk_pop_c);

  // Overflow flag latches a push rejected for lack of room until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ps_lp_stcky = {ovf_q, full, !ps_lp_act};
`else
  assign ps_lp_stcky = 3'b000;
`endif

endmodule

// File: tb/tb_ps_loop_ctrl.sv
// Directed bench for ps_loop_ctrl with a queue-based loop-stack model.
module tb_ps_loop_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] ps_faddr;
  logic        ps_lp_stall;
  logic        ps_lp_push;
  logic [15:0] ps_lp_start_add;
  logic [15:0] ps_lp_end_add;
  logic [15:0] ps_lp_cnt;
  logic        ps_lp_pop;
  logic        ps_lp_jmp;
  logic [15:0] ps_lp_jmp_add;
  logic        ps_lp_act;
  logic [15:0] ps_lp_curcnt;
  logic        ps_lp_err;
  logic [2:0]  ps_lp_stcky;

  ps_loop_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ps_faddr        (ps_faddr),
    .ps_lp_stall     (ps_lp_stall),
    .ps_lp_push      (ps_lp_push),
    .ps_lp_start_add (ps_lp_start_add),
    .ps_lp_end_add   (ps_lp_end_add),
    .ps_lp_cnt       (ps_lp_cnt),
    .ps_lp_pop       (ps_lp_pop),
    .ps_lp_jmp       (ps_lp_jmp),
    .ps_lp_jmp_add   (ps_lp_jmp_add),
    .ps_lp_act       (ps_lp_act),
    .ps_lp_curcnt    (ps_lp_curcnt),
    .ps_lp_err       (ps_lp_err),
    .ps_lp_stcky     (ps_lp_stcky)
  );

`ifdef PS_LOOP_STCKY_EN
  localparam logic [2:0] ST_EMPTY     = 3'b001;
  localparam logic [2:0] ST_FULL_OVF  = 3'b110;
  localparam logic [2:0] ST_EMPTY_OVF = 3'b101;
  localparam bit         STCKY_ON     = 1'b1;
`else
  localparam logic [2:0] ST_EMPTY     = 3'b000;
  localparam logic [2:0] ST_FULL_OVF  = 3'b000;
  localparam logic [2:0] ST_EMPTY_OVF = 3'b000;
  localparam bit         STCKY_ON     = 1'b0;
`endif
  localparam int DEPTH = 4;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Loop-stack model: a queue of loops, most recent at the back.
  typedef struct {
    logic [15:0] s;
    logic [15:0] e;
    logic [15:0] c;
  } ment_t;

  ment_t stk[$];
  bit    m_ovf;
  bit    m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
    end else begin
      bit    hit;
      ment_t t;
      hit = 1'b0;
      if (stk.size() != 0) hit = !ps_lp_stall && (ps_faddr == stk[stk.size()-1].e);
      m_err = 1'b0;
      if (ps_lp_pop) begin
        if (stk.size() == 0) m_err = 1'b1;
        else void'(stk.pop_back());
      end else if (hit) begin
        t = stk.pop_back();
        if (t.c > 16'd1) begin
          t.c = t.c - 16'd1;
          stk.push_back(t);
        end
      end
      if (ps_lp_push) begin
        if (ps_lp_cnt == 16'd0) begin
          m_err = 1'b1;
        end else if (stk.size() >= DEPTH) begin
          m_err = 1'b1;
          m_ovf = 1'b1;
        end else begin
          t.s = ps_lp_start_add;
          t.e = ps_lp_end_add;
          t.c = ps_lp_cnt;
          stk.push_back(t);
        end
      end
    end
  end

  // Compare process: every cycle, mid low phase, against the model.
  logic        e_act, e_hit, e_jmp;
  logic [15:0] e_add, e_cur;
  logic [2:0]  e_st;
  always @(negedge clk) begin
    if (chk_en) begin
      #3;
      e_act = (stk.size() != 0);
      e_add = 16'h0;
      e_cur = 16'h0;
      e_hit = 1'b0;
      if (e_act) begin
        e_add = stk[stk.size()-1].s;
        e_cur = stk[stk.size()-1].c;
        e_hit = !ps_lp_stall && (ps_faddr == stk[stk.size()-1].e);
      end
      e_jmp = e_hit && (e_cur > 16'd1);
      e_st  = STCKY_ON ? {m_ovf, stk.size() == DEPTH, !e_act} : 3'b000;
      chk("cyc_act", 32'(ps_lp_act), 32'(e_act));
      chk("cyc_jmp", 32'(ps_lp_jmp), 32'(e_jmp));
      chk("cyc_jmp_add", 32'(ps_lp_jmp_add), 32'(e_add));
      chk("cyc_curcnt", 32'(ps_lp_curcnt), 32'(e_cur));
      chk("cyc_err", 32'(ps_lp_err), 32'(m_err));
      chk("cyc_stcky", 32'(ps_lp_stcky), 32'(e_st));
    end
  end

  // Directed stimulus helpers; samples are taken at the same point as the compare process.
  logic        s_jmp, s_act, s_err;
  logic [15:0] s_add, s_cur;
  logic [2:0]  s_st;

  task automatic tick();
    #3;
    s_jmp = ps_lp_jmp;
    s_add = ps_lp_jmp_add;
    s_act = ps_lp_act;
    s_cur = ps_lp_curcnt;
    s_err = ps_lp_err;
    s_st  = ps_lp_stcky;
    @(negedge clk);
    ps_lp_push = 1'b0;
    ps_lp_pop  = 1'b0;
  endtask

  task automatic do_push(input logic [15:0] s, input logic [15:0] e, input logic [15:0] c);
    ps_lp_push      = 1'b1;
    ps_lp_start_add = s;
    ps_lp_end_add   = e;
    ps_lp_cnt       = c;
  endtask

  logic [15:0] pc;
  int inner_j, outer_j, body;

  initial begin
    rst = 1'b0;
    ps_faddr = 16'h0; ps_lp_stall = 1'b0; ps_lp_push = 1'b0; ps_lp_pop = 1'b0;
    ps_lp_start_add = 16'h0; ps_lp_end_add = 16'h0; ps_lp_cnt = 16'h0;

    // Reset state
    @(negedge clk);
    tick();
    chk("rst_jmp", 32'(s_jmp), 32'd0);
    chk("rst_add", 32'(s_add), 32'd0);
    chk("rst_act", 32'(s_act), 32'd0);
    chk("rst_cur", 32'(s_cur), 32'd0);
    chk("rst_err", 32'(s_err), 32'd0);
    chk("rst_stcky", 32'(s_st), 32'(ST_EMPTY));
    rst = 1'b1;
    chk_en = 1'b1;

    // 1: single loop 0x10..0x12, three iterations
    ps_faddr = 16'h0F;
    do_push(16'h10, 16'h12, 16'd3);
    tick();
    for (int p = 0; p < 3; p++) begin
      for (int a = 16'h10; a <= 16'h12; a++) begin
        ps_faddr = 16'(a);
        tick();
        if (a == 16'h12) begin
          chk("t1_jmp", 32'(s_jmp), (p < 2) ? 32'd1 : 32'd0);
          chk("t1_cnt", 32'(s_cur), 32'(3 - p));
          if (p < 2) chk("t1_add", 32'(s_add), 32'h10);
        end
      end
    end
    ps_faddr = 16'h13;
    tick();
    chk("t1_act", 32'(s_act), 32'd0);
    chk("t1_stcky", 32'(s_st), 32'(ST_EMPTY));

    // 2: nested loops driven by a simple fetch model
    pc = 16'h1F;
    ps_faddr = pc;
    do_push(16'h20, 16'h26, 16'd2);
    tick();
    pc = 16'h20; inner_j = 0; outer_j = 0; body = 0;
    for (int k = 0; k < 100 && pc != 16'h27; k++) begin
      ps_faddr = pc;
      if (pc == 16'h21) do_push(16'h22, 16'h24, 16'd2);
      tick();
      if (s_jmp && pc == 16'h24) inner_j++;
      if (s_jmp && pc == 16'h26) outer_j++;
      if (pc == 16'h22) body++;
      pc = s_jmp ? s_add : pc + 16'd1;
    end
    chk("t2_exit", 32'(pc), 32'h27);
    chk("t2_inner_jmps", 32'(inner_j), 32'd2);
    chk("t2_outer_jmps", 32'(outer_j), 32'd1);
    chk("t2_inner_passes", 32'(body), 32'd4);
    ps_faddr = 16'h27;
    tick();
    chk("t2_act", 32'(s_act), 32'd0);

    // 4: zero-count push and pop while empty
    ps_faddr = 16'h100;
    do_push(16'h01, 16'h02, 16'd0);
    tick();
    tick();
    chk("t4_err_cnt0", 32'(s_err), 32'd1);
    chk("t4_act", 32'(s_act), 32'd0);
    ps_lp_pop = 1'b1;
    tick();
    tick();
    chk("t4_err_pop", 32'(s_err), 32'd1);
    chk("t4_stcky", 32'(s_st), 32'(ST_EMPTY));
    tick();
    chk("t4_err_clr", 32'(s_err), 32'd0);

    // 5: stall at loop end holds the count, redirect on first unstalled cycle
    ps_faddr = 16'h4F;
    do_push(16'h50, 16'h52, 16'd2);
    tick();
    ps_faddr = 16'h52;
    ps_lp_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_stall_jmp", 32'(s_jmp), 32'd0);
      chk("t5_stall_cnt", 32'(s_cur), 32'd2);
    end
    ps_lp_stall = 1'b0;
    tick();
    chk("t5_jmp", 32'(s_jmp), 32'd1);
    chk("t5_add", 32'(s_add), 32'h50);
    ps_faddr = 16'h50; tick();
    ps_faddr = 16'h51; tick();
    ps_faddr = 16'h52; tick();
    chk("t5_last_jmp", 32'(s_jmp), 32'd0);
    chk("t5_last_cnt", 32'(s_cur), 32'd1);
    ps_faddr = 16'h53; tick();
    chk("t5_act", 32'(s_act), 32'd0);

    // 3: overflow with five pushes, then pop+push replace while full
    ps_faddr = 16'h100;
    for (int i = 0; i < 5; i++) begin
      do_push(16'(16'h60 + 4 * i), 16'(16'h62 + 4 * i), 16'(i + 1));
      tick();
    end
    tick();
    chk("t3_err", 32'(s_err), 32'd1);
    chk("t3_cur", 32'(s_cur), 32'd4);
    chk("t3_add", 32'(s_add), 32'h6C);
    chk("t3_stcky", 32'(s_st), 32'(ST_FULL_OVF));
    ps_lp_pop = 1'b1;
    do_push(16'h90, 16'h91, 16'd9);
    tick();
    tick();
    chk("t3_repl_err", 32'(s_err), 32'd0);
    chk("t3_repl_cur", 32'(s_cur), 32'd9);
    chk("t3_repl_stcky", 32'(s_st), 32'(ST_FULL_OVF));
    for (int i = 0; i < 4; i++) begin
      ps_lp_pop = 1'b1;
      tick();
    end
    tick();
    chk("t3_empty_act", 32'(s_act), 32'd0);
    chk("t3_empty_stcky", 32'(s_st), 32'(ST_EMPTY_OVF));

    // 6: reset mid-loop, then a single-instruction loop from an empty stack
    ps_faddr = 16'h6F;
    do_push(16'h70, 16'h71, 16'd5);
    tick();
    ps_faddr = 16'h70;
    tick();
    chk("t6_cnt5", 32'(s_cur), 32'd5);
    rst = 1'b0;
    tick();
    chk("t6_rst_act", 32'(s_act), 32'd0);
    chk("t6_rst_cur", 32'(s_cur), 32'd0);
    chk("t6_rst_add", 32'(s_add), 32'd0);
    chk("t6_rst_err", 32'(s_err), 32'd0);
    chk("t6_rst_stcky", 32'(s_st), 32'(ST_EMPTY));
    rst = 1'b1;
    ps_faddr = 16'h7F;
    do_push(16'h80, 16'h80, 16'd2);
    tick();
    ps_faddr = 16'h80;
    tick();
    chk("t6_sil_jmp", 32'(s_jmp), 32'd1);
    chk("t6_sil_add", 32'(s_add), 32'h80);
    chk("t6_sil_cnt", 32'(s_cur), 32'd2);
    tick();
    chk("t6_sil_last", 32'(s_jmp), 32'd0);
    chk("t6_sil_cnt1", 32'(s_cur), 32'd1);
    tick();
    chk("t6_act", 32'(s_act), 32'd0);
    chk("t6_stcky", 32'(s_st), 32'(ST_EMPTY));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
